imm_encoder: RTL and testbench

Packs a 32-bit immediate into the immediate bit positions of a RISC-V instruction word for I, S, B and J formats. It is the inverse of the datapath's immediate-extension logic. It feeds the instruction-memory loader and the self-check bench, taking requests over a valid/ready handshake. Results are buffered in a 2-entry output FIFO, and each result carries a representability error flag.

---
 rtl/imm_encoder.sv | 131 +++++++++++++
 tb/tb_imm_encoder.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/imm_encoder.sv
// Immediate packer for RISC-V I/S/B/J instruction words. Results are queued
// in a 2-entry FIFO together with a flag that marks unrepresentable immediates.
module imm_encoder (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        valid_i,
    output logic        ready_o,
    input  logic [1:0]  immsrc_i,
    input  logic [31:0] imm_i,
    input  logic [31:0] base_i,
    output logic        valid_o,
    input  logic        ready_i,
    output logic [31:0] instr_o,
    output logic        err_o,
    output logic        sticky_err_o,
    output logic [15:0] count_o
);

    localparam logic [1:0] FMT_I = 2'b00;
    localparam logic [1:0] FMT_S = 2'b01;
    localparam logic [1:0] FMT_B = 2'b10;
    localparam logic [1:0] FMT_J = 2'b11;

    localparam logic [1:0] OCC_EMPTY = 2'd0;
    localparam logic [1:0] OCC_FULL  = 2'd2;

    // Bits of the instruction word that carry the immediate for each format.
    function automatic logic [31:0] imm_mask(input logic [1:0] fmt);
        logic [31:0] m;
        case (fmt)
            FMT_I:   m = 32'hFFF0_0000;
            FMT_S:   m = 32'hFE00_0F80;
            FMT_B:   m = 32'hFE00_0F80;
            FMT_J:   m = 32'hFFFF_F000;
            default: m = 32'h0000_0000;
        endcase
        return m;
    endfunction

    // Scatter the immediate into its instruction positions, zero elsewhere.
    function automatic logic [31:0] imm_place(input logic [1:0] fmt, input logic [31:0] imm);
        logic [31:0] p;
        case (fmt)
            FMT_I:   p = {imm[11:0], 20'h00000};
            FMT_S:   p = {imm[11:5], 13'h0000, imm[4:0], 7'h00};
            FMT_B:   p = {imm[12], imm[10:5], 13'h0000, imm[4:1], imm[11], 7'h00};
            FMT_J:   p = {imm[20], imm[10:1], imm[11], imm[19:12], 12'h000};
            default: p = 32'h0000_0000;
        endcase
        return p;
    endfunction

    // An immediate fits when every bit above the field's sign bit copies it;
    // branch and jump offsets must additionally be halfword aligned.
    function automatic logic imm_error(input logic [1:0] fmt, input logic [31:0] imm);
        logic e;
        case (fmt)
            FMT_I,
            FMT_S:   e = !((imm[31:11] == 21'h000000) || (imm[31:11] == 21'h1FFFFF));
            FMT_B:   e = !((imm[31:12] == 20'h00000) || (imm[31:12] == 20'hFFFFF)) || imm[0];
            FMT_J:   e = !((imm[31:20] == 12'h000) || (imm[31:20] == 12'hFFF)) || imm[0];
            default: e = 1'b1;
        endcase
        return e;
    endfunction

    logic [31:0] mem_instr_r [2];
    logic        mem_err_r   [2];
    logic        wr_ptr_r;
    logic        rd_ptr_r;
    logic [1:0]  occ_r;
    logic [15:0] count_r;
    logic        sticky_r;

    logic        push_s;
    logic        pop_s;
    logic [1:0]  occ_nxt_s;
    logic [31:0] enc_instr_s;
    logic        enc_err_s;

    // Request encoding and FIFO handshake decode.
    always_comb begin
        enc_instr_s = (base_i & ~imm_mask(immsrc_i)) | imm_place(immsrc_i, imm_i);
        enc_err_s   = imm_error(immsrc_i, imm_i);
        push_s      = valid_i && (occ_r != OCC_FULL);
        pop_s       = (occ_r != OCC_EMPTY) && ready_i;
        case ({push_s, pop_s})
            2'b10:   occ_nxt_s = occ_r + 2'd1;
            2'b01:   occ_nxt_s = occ_r - 2'd1;
            default: occ_nxt_s = occ_r;
        endcase
    end

    // FIFO storage, pointers, occupancy and request statistics.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            mem_instr_r[0] <= 32'h0000_0000;
            mem_instr_r[1] <= 32'h0000_0000;
            mem_err_r[0]   <= 1'b0;
            mem_err_r[1]   <= 1'b0;
            wr_ptr_r       <= 1'b0;
            rd_ptr_r       <= 1'b0;
            occ_r          <= OCC_EMPTY;
            count_r        <= 16'h0000;
            sticky_r       <= 1'b0;
        end else begin
            if (push_s) begin
                mem_instr_r[wr_ptr_r] <= enc_instr_s;
                mem_err_r[wr_ptr_r]   <= enc_err_s;
                wr_ptr_r              <= ~wr_ptr_r;
                count_r               <= count_r + 16'h0001;
                sticky_r              <= sticky_r | enc_err_s;
            end
            if (pop_s) begin
                rd_ptr_r <= ~rd_ptr_r;
            end
            occ_r <= occ_nxt_s;
        end
    end

    // All outputs are taken straight from registered state.
    always_comb begin
        ready_o      = (occ_r != OCC_FULL);
        valid_o      = (occ_r != OCC_EMPTY);
        instr_o      = mem_instr_r[rd_ptr_r];
        err_o        = mem_err_r[rd_ptr_r];
        sticky_err_o = sticky_r;
        count_o      = count_r;
    end

endmodule

// File: tb/tb_imm_encoder.sv
// Bench for imm_encoder: queue-based reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_imm_encoder;

    logic        clk = 1'b0;
    logic        rst_i = 1'b1;
    logic        valid_i = 1'b0;
    logic        ready_o;
    logic [1:0]  immsrc_i = 2'b00;
    logic [31:0] imm_i = 32'h0;
    logic [31:0] base_i = 32'h0;
    logic        valid_o;
    logic        ready_i = 1'b0;
    logic [31:0] instr_o;
    logic        err_o;
    logic        sticky_err_o;
    logic [15:0] count_o;

    int checks = 0;
    int errors = 0;

    imm_encoder dut (
        .clk_i(clk), .rst_i(rst_i), .valid_i(valid_i), .ready_o(ready_o),
        .immsrc_i(immsrc_i), .imm_i(imm_i), .base_i(base_i),
        .valid_o(valid_o), .ready_i(ready_i), .instr_o(instr_o), .err_o(err_o),
        .sticky_err_o(sticky_err_o), .count_o(count_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference encoding: write each immediate field into a copy of base.
    function automatic logic [31:0] model_encode(input logic [1:0] fmt, input logic [31:0] imm,
                                                 input logic [31:0] base);
        logic [31:0] r;
        r = base;
        case (fmt)
            2'd0: r[31:20] = imm[11:0];
            2'd1: begin r[31:25] = imm[11:5]; r[11:7] = imm[4:0]; end
            2'd2: begin r[31] = imm[12]; r[7] = imm[11]; r[30:25] = imm[10:5]; r[11:8] = imm[4:1]; end
            default: begin r[31] = imm[20]; r[19:12] = imm[19:12]; r[20] = imm[11]; r[30:21] = imm[10:1]; end
        endcase
        return r;
    endfunction

    // Reference error rule: signed range check plus alignment for offsets.
    function automatic logic model_err(input logic [1:0] fmt, input logic [31:0] imm);
        longint s;
        s = longint'($signed(imm));
        case (fmt)
            2'd0, 2'd1: return (s < -2048) || (s > 2047);
            2'd2:       return (s < -4096) || (s > 4095) || (imm[0] == 1'b1);
            default:    return (s < -1048576) || (s > 1048575) || (imm[0] == 1'b1);
        endcase
    endfunction

    // Inputs as seen by the DUT at the rising edge.
    logic        p_rst, p_valid, p_ready;
    logic [1:0]  p_fmt;
    logic [31:0] p_imm, p_base;
    always @(posedge clk) begin
        p_rst   <= rst_i;
        p_valid <= valid_i;
        p_ready <= ready_i;
        p_fmt   <= immsrc_i;
        p_imm   <= imm_i;
        p_base  <= base_i;
    end

    logic [32:0] q[$];
    logic [32:0] popped;
    logic [15:0] m_count = 16'h0;
    logic        m_sticky = 1'b0;
    logic        started = 1'b0;
    logic        m_acc, m_pop, e;

    // Advance the model by the edge just passed, then compare all outputs.
    always @(negedge clk) begin
        if (p_rst === 1'b1) begin
            q.delete();
            m_count  = 16'h0;
            m_sticky = 1'b0;
            started  = 1'b1;
        end else if (started) begin
            m_acc = p_valid && (q.size() < 2);
            m_pop = (q.size() != 0) && p_ready;
            if (m_pop) popped = q.pop_front();
            if (m_acc) begin
                e = model_err(p_fmt, p_imm);
                q.push_back({e, model_encode(p_fmt, p_imm, p_base)});
                m_count = m_count + 16'h1;
                if (e) m_sticky = 1'b1;
            end
        end
        if (started) begin
            chk("valid_o", {31'h0, valid_o}, {31'h0, q.size() != 0});
            chk("ready_o", {31'h0, ready_o}, {31'h0, q.size() != 2});
            chk("count_o", {16'h0, count_o}, {16'h0, m_count});
            chk("sticky_err_o", {31'h0, sticky_err_o}, {31'h0, m_sticky});
            if (q.size() != 0) begin
                chk("instr_o", instr_o, q[0][31:0]);
                chk("err_o", {31'h0, err_o}, {31'h0, q[0][32]});
            end else if (p_rst === 1'b1) begin
                chk("instr_o_rst", instr_o, 32'h0);
                chk("err_o_rst", {31'h0, err_o}, 32'h0);
            end
        end
    end

    task automatic drive(input logic v, input logic [1:0] f, input logic [31:0] imm,
                         input logic [31:0] base);
        valid_i  = v;
        immsrc_i = f;
        imm_i    = imm;
        base_i   = base;
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    initial begin
        int r;
        logic [31:0] rimm;

        // Pin the reference model against hand-computed encodings.
        chk("model_I", model_encode(2'd0, 32'hFFFF_FFFF, 32'h13), 32'hFFF0_0013);
        chk("model_S", model_encode(2'd1, 32'd8, 32'h2023), 32'h0000_2423);
        chk("model_B", model_encode(2'd2, 32'hFFFF_FFFC, 32'h63), 32'hFE00_0EE3);
        chk("model_J", model_encode(2'd3, 32'd2048, 32'h6F), 32'h0010_006F);
        chk("model_err_I", {31'h0, model_err(2'd0, 32'd2048)}, 32'h1);
        chk("model_err_B", {31'h0, model_err(2'd2, 32'd3)}, 32'h1);
        chk("model_ok_B", {31'h0, model_err(2'd2, 32'hFFFF_F000)}, 32'h0);

        tick(); tick();
        rst_i = 1'b0;
        chk("rst_valid", {31'h0, valid_o}, 32'h0);
        chk("rst_ready", {31'h0, ready_o}, 32'h1);
        chk("rst_count", {16'h0, count_o}, 32'h0);

        // I-type, then S/B/J back to back.
        ready_i = 1'b1;
        drive(1'b1, 2'd0, 32'hFFFF_FFFF, 32'h13); tick();
        chk("I_instr", instr_o, 32'hFFF0_0013);
        chk("I_err", {31'h0, err_o}, 32'h0);
        chk("I_count", {16'h0, count_o}, 32'd1);
        drive(1'b1, 2'd1, 32'd8, 32'h2023); tick();
        chk("S_instr", instr_o, 32'h0000_2423);
        drive(1'b1, 2'd2, 32'hFFFF_FFFC, 32'h63); tick();
        chk("B_instr", instr_o, 32'hFE00_0EE3);
        drive(1'b1, 2'd3, 32'd2048, 32'h6F); tick();
        chk("J_instr", instr_o, 32'h0010_006F);
        chk("J_err", {31'h0, err_o}, 32'h0);

        // Unrepresentable immediates.
        drive(1'b1, 2'd0, 32'd2048, 32'h13); tick();
        chk("errI_instr", instr_o, 32'h8000_0013);
        chk("errI_err", {31'h0, err_o}, 32'h1);
        chk("errI_sticky", {31'h0, sticky_err_o}, 32'h1);
        drive(1'b1, 2'd2, 32'd3, 32'h63); tick();
        chk("errB_instr", instr_o, 32'h0000_0163);
        chk("errB_err", {31'h0, err_o}, 32'h1);
        drive(1'b0, 2'd0, 32'h0, 32'h0); tick();

        // Back-pressure: three requests, only two fit.
        ready_i = 1'b0;
        drive(1'b1, 2'd0, 32'd1, 32'h13); tick();
        drive(1'b1, 2'd0, 32'd2, 32'h13); tick();
        drive(1'b1, 2'd0, 32'd3, 32'h13);
        chk("bp_ready", {31'h0, ready_o}, 32'h0);
        chk("bp_count", {16'h0, count_o}, 32'd8);
        tick();
        chk("bp_hold_count", {16'h0, count_o}, 32'd8);
        chk("bp_head", instr_o, 32'h0010_0013);
        ready_i = 1'b1; tick();
        chk("bp_pop_ready", {31'h0, ready_o}, 32'h1);
        chk("bp_pop_count", {16'h0, count_o}, 32'd8);
        chk("bp_pop_head", instr_o, 32'h0020_0013);
        tick();
        chk("bp_third_count", {16'h0, count_o}, 32'd9);
        chk("bp_third_head", instr_o, 32'h0030_0013);
        drive(1'b0, 2'd0, 32'h0, 32'h0); tick();

        // Steady push+pop at occupancy 1.
        for (int i = 0; i < 11; i++) begin
            drive(1'b1, 2'(i), 32'(i * 4), 32'h0000_0033 + 32'(i));
            tick();
            chk("pp_ready", {31'h0, ready_o}, 32'h1);
            chk("pp_valid", {31'h0, valid_o}, 32'h1);
        end
        drive(1'b0, 2'd0, 32'h0, 32'h0); tick();

        // Reset with a full FIFO and sticky error set.
        ready_i = 1'b0;
        drive(1'b1, 2'd0, 32'd4096, 32'h13); tick();
        drive(1'b1, 2'd1, 32'hFFFF_0000, 32'h23); tick();
        chk("full_ready", {31'h0, ready_o}, 32'h0);
        chk("full_sticky", {31'h0, sticky_err_o}, 32'h1);
        rst_i = 1'b1; tick();
        rst_i = 1'b0;
        drive(1'b0, 2'd0, 32'h0, 32'h0);
        chk("mrst_valid", {31'h0, valid_o}, 32'h0);
        chk("mrst_ready", {31'h0, ready_o}, 32'h1);
        chk("mrst_count", {16'h0, count_o}, 32'h0);
        chk("mrst_sticky", {31'h0, sticky_err_o}, 32'h0);
        ready_i = 1'b1;
        drive(1'b1, 2'd3, 32'd4, 32'h6F); tick();
        chk("post_rst_instr", instr_o, 32'h0040_006F);
        chk("post_rst_count", {16'h0, count_o}, 32'd1);
        drive(1'b0, 2'd0, 32'h0, 32'h0); tick();

        // Randomized traffic with occasional resets.
        for (int i = 0; i < 3000; i++) begin
            r = int'($urandom_range(0, 3));
            case (r)
                0: rimm = $urandom;
                1: rimm = 32'($urandom_range(0, 8191)) - 32'd4096;
                2: rimm = 32'($urandom_range(0, 32'h3F_FFFF)) - 32'h20_0000;
                default: rimm = 32'($urandom_range(0, 4095)) - 32'd2048;
            endcase
            drive($urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)), rimm, $urandom);
            ready_i = ($urandom_range(0, 2) != 0);
            rst_i   = ($urandom_range(0, 299) == 0);
            tick();
        end
        rst_i = 1'b0;
        drive(1'b0, 2'd0, 32'h0, 32'h0);
        tick(); tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
